// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_driver                                             |
// | Description : Eight-digit multiplexed seven-segment driver with per-frame  |
// |               snapshot, inter-digit anode guard and whole-display blink.   |
// |               Define SEG_LZ_BLANK_EN to enable leading-zero blanking.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd4,
    input  logic [3:0] bcd5,
    input  logic [3:0] bcd6,
    input  logic [3:0] bcd7,
    input  logic [7:0] dp_in,
    input  logic       blink_en,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CNT_W   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   C_CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_GUARD      = CNT_W'(GUARD_CYCLES);
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    localparam logic [1:0] ST_RESET      = 2'd0;
    localparam logic [1:0] ST_SCAN_FIRST = 2'd1;
    localparam logic [1:0] ST_SCAN       = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0][3:0]    digit_q, digit_d;
    logic [7:0]         snap_dp_q, snap_dp_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_start_q, frame_start_d;

    logic               w_slot_end;
    logic               w_snap_point;
    logic               w_blink_wrap;
    logic               w_snap_en;
    logic               w_lz_blank;
    logic               w_an_force;
    logic [3:0]         w_cur_digit;

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:      state_d = ST_SCAN_FIRST;
            ST_SCAN_FIRST: if (w_snap_point) state_d = ST_SCAN;
            ST_SCAN:       state_d = ST_SCAN;
            default:       state_d = ST_SCAN_FIRST;
        endcase
    end

    always_comb begin
        w_snap_en = 1'b0;
        case (state_q)
            ST_SCAN_FIRST,
            ST_SCAN:       w_snap_en = w_snap_point;
            default:       w_snap_en = 1'b0;
        endcase
    end

    // ------------------------------------------------ counters / snapshot ---
    always_comb begin
        w_slot_end   = (cnt_q == C_CNT_LAST);
        w_snap_point = w_slot_end && (idx_q == 3'd7);
        cnt_d        = w_slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = w_slot_end ? idx_q + 3'd1 : idx_q;

        w_blink_wrap = (blink_cnt_q == C_BLINK_LAST);
        blink_cnt_d  = w_blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        phase_d      = phase_q ^ w_blink_wrap;

        digit_d      = digit_q;
        snap_dp_d    = snap_dp_q;
        if (w_snap_en) begin
            digit_d   = {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
            snap_dp_d = dp_in;
        end
    end

    // ------------------------------------------------ leading-zero blank ---
`ifdef SEG_LZ_BLANK_EN
    logic [7:0] w_nz;
    logic [7:0] w_keep;

    // A digit stays lit if it or any more significant digit is "nonzero".
    for (genvar gi = 0; gi < 8; gi++) begin : g_lz
        assign w_nz[gi]   = (digit_q[gi] != 4'd0) || snap_dp_q[gi];
        assign w_keep[gi] = |w_nz[7:gi];
    end

    assign w_lz_blank = (idx_q != 3'd0) && !w_keep[idx_q];
`else
    assign w_lz_blank = 1'b0;
`endif

    // ------------------------------------------------------ output decode ---
    always_comb begin
        w_cur_digit = digit_q[idx_q];
        case (w_cur_digit)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;
        endcase

        w_an_force    = (cnt_q < C_GUARD) || (blink_en && phase_q) || w_lz_blank;
        an_d          = w_an_force ? 8'hFF : ~(8'd1 << idx_q);
        dp_d          = ~snap_dp_q[idx_q];
        frame_start_d = w_snap_en;
    end

    // ---------------------------------------------------------- registers ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            digit_q       <= '0;
            snap_dp_q     <= 8'h00;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            digit_q       <= digit_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_driver                                          |
// | Description : Directed self-checking bench for seg7_scan_driver.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_driver;

    localparam int DC = 4;
    localparam int GC = 1;
    localparam int BC = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bcd [8];
    logic [7:0] dp_in = 8'h00;
    logic       blink_en = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int         k = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] snap [8];
    logic [7:0] snap_dp = 8'h00;

    seg7_scan_driver #(
        .DIGIT_CYCLES(DC),
        .GUARD_CYCLES(GC),
        .BLINK_CYCLES(BC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd0       (bcd[0]),
        .bcd1       (bcd[1]),
        .bcd2       (bcd[2]),
        .bcd3       (bcd[3]),
        .bcd4       (bcd[4]),
        .bcd5       (bcd[5]),
        .bcd6       (bcd[6]),
        .bcd7       (bcd[7]),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // One clock; outputs after edge k reflect slot state at cycle k-1.
    task automatic step();
        logic       bl;
        logic       blank;
        logic [7:0] ean;
        logic       edp;
        logic       efs;
        int         t;
        int         cnt;
        int         idx;
        int         ph;
        bl = blink_en;
        @(posedge clk);
        @(negedge clk);
        k++;
        t     = k - 1;
        cnt   = t % DC;
        idx   = (t / DC) % 8;
        ph    = (t / BC) % 2;
        blank = (cnt < GC) || (bl && (ph == 1));
`ifdef SEG_LZ_BLANK_EN
        if (idx != 0) begin
            logic hit;
            hit = 1'b0;
            for (int j = idx; j < 8; j++)
                if ((snap[j] != 4'd0) || snap_dp[j]) hit = 1'b1;
            if (!hit) blank = 1'b1;
        end
`endif
        ean = blank ? 8'hFF : ~(8'h01 << idx);
        edp = ~snap_dp[idx];
        efs = ((k % (8 * DC)) == 0);
        chk("an", an, ean);
        chk("seg", seg, exp_seg(snap[idx]));
        chk("dp", dp, edp);
        chk("frame_start", frame_start, efs);
        if ((k % (8 * DC)) == 0) begin
            snap    = bcd;
            snap_dp = dp_in;
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, an, 8'hFF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_fs"}, frame_start, 1'b0);
    endtask

    task automatic clear_snap();
        for (int i = 0; i < 8; i++) snap[i] = 4'd0;
        snap_dp = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bcd[i] = 4'(i + 1);
        clear_snap();

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        k = 0;

        // First frame shows zeros; second frame shows 8..1
        run_to(4);
        chk("f0_d0_seg", seg, 7'h40);
        run_to(34);
        chk("f1_d0_an", an, 8'hFE);
        chk("f1_d0_seg", seg, 7'h79);
        run_to(64);
        chk("f1_d7_an", an, 8'h7F);
        chk("f1_d7_seg", seg, 7'h00);

        // Mid-frame input change held off until the next snapshot
        run_to(66);
        chk("f2_d0_seg", seg, 7'h79);
        run_to(70);
        bcd[0] = 4'd9;
        run_to(98);
        chk("f3_d0_seg", seg, 7'h10);
        chk("f3_d0_an", an, 8'hFE);

        // Invalid digit and decimal point
        run_to(128);
        bcd[3] = 4'd12;
        dp_in  = 8'h04;
        run_to(170);
        chk("f5_d2_dp", dp, 1'b0);
        chk("f5_d2_an", an, 8'hFB);
        run_to(174);
        chk("f5_d3_seg", seg, 7'h3F);
        chk("f5_d3_an", an, 8'hF7);

        // Blinking
        run_to(192);
        blink_en = 1'b1;
        run_to(200);
        chk("blink_off_an", an, 8'hFF);
        run_to(266);
        chk("blink_on_an", an, 8'hFB);
        run_to(448);

        // 00000305
        blink_en = 1'b0;
        dp_in    = 8'h00;
        for (int i = 0; i < 8; i++) bcd[i] = 4'd0;
        bcd[0] = 4'd5;
        bcd[2] = 4'd3;
        run_to(490);
        chk("lz_d2_an", an, 8'hFB);
        chk("lz_d2_seg", seg, 7'h30);
        run_to(495);
`ifdef SEG_LZ_BLANK_EN
        chk("lz_d3_an", an, 8'hFF);
`else
        chk("lz_d3_an", an, 8'hF7);
`endif
        run_to(544);

        // All zeros
        for (int i = 0; i < 8; i++) bcd[i] = 4'd0;
        run_to(582);
`ifdef SEG_LZ_BLANK_EN
        chk("zero_d1_an", an, 8'hFF);
`else
        chk("zero_d1_an", an, 8'hFD);
`endif
        chk("zero_d1_seg", seg, 7'h40);

        // Asynchronous reset at idx=3, cnt=2
        for (int i = 0; i < 8; i++) bcd[i] = 4'(i + 1);
        run_to(622);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("held");
        rst_n = 1'b1;
        k = 0;
        clear_snap();
        run_to(1);
        chk("rel_c1_an", an, 8'hFF);
        run_to(2);
        chk("rel_c2_an", an, 8'hFE);
        chk("rel_c2_seg", seg, 7'h40);
        run_to(4);
        chk("rel_c4_an", an, 8'hFE);
        run_to(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
